// File: rtl/axi4_lite_if.sv
// axi4_lite_if: AXI4-Lite bus bundle (32-bit data, 4-bit strobe) between one master and one slave
// Ports: ADDRESS sets the AW/AR address width.
//        The master modport drives AW/W/AR valids, addresses, data and strobes, and drives BREADY and RREADY.
//        The slave modport drives the readys, BRESP/BVALID and RDATA/RRESP/RVALID.
interface axi4_lite_if #(parameter int ADDRESS = 32);
    logic [ADDRESS-1:0] M_AWADDR;
    logic               M_AWVALID;
    logic               M_AWREADY;
    logic [31:0]        M_WDATA;
    logic [3:0]         M_WSTRB;
    logic               M_WVALID;
    logic               M_WREADY;
    logic [1:0]         M_BRESP;
    logic               M_BVALID;
    logic               M_BREADY;
    logic [ADDRESS-1:0] M_ARADDR;
    logic               M_ARVALID;
    logic               M_ARREADY;
    logic [31:0]        M_RDATA;
    logic [1:0]         M_RRESP;
    logic               M_RVALID;
    logic               M_RREADY;

    modport master (
        output M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
               M_ARADDR, M_ARVALID, M_RREADY,
        input  M_AWREADY, M_WREADY, M_BRESP, M_BVALID, M_ARREADY, M_RDATA, M_RRESP, M_RVALID
    );

    modport slave (
        input  M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
               M_ARADDR, M_ARVALID, M_RREADY,
        output M_AWREADY, M_WREADY, M_BRESP, M_BVALID, M_ARREADY, M_RDATA, M_RRESP, M_RVALID
    );
endinterface

// File: rtl/axi4_lite_master.sv
// axi4_lite_master: converts single user commands into AXI4-Lite transactions, one outstanding at a time
// Ports: ACLK (rising edge) and ARESETN (asynchronous, active-low) are the clock and reset.
//        cmd_*: command handshake, write/read select, address, write data and strobes.
//        rsp_*: one-cycle completion pulse with read data (0 for writes) and captured BRESP/RRESP.
//        m: AXI4-Lite master side of the bus; every output on it is registered.
module axi4_lite_master #(
    parameter int ADDRESS = 32
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDRESS-1:0] cmd_addr,
    input  logic [31:0]        cmd_wdata,
    input  logic [3:0]         cmd_wstrb,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic [1:0]         rsp_resp,
    axi4_lite_if.master        m
);
    typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA} state_t;

    state_t             state, state_n;
    logic [ADDRESS-1:0] addr_q, addr_n;
    logic [31:0]        wdata_q, wdata_n;
    logic [3:0]         wstrb_q, wstrb_n;
    logic               awvalid_q, awvalid_n;
    logic               wvalid_q, wvalid_n;
    logic               bready_q, bready_n;
    logic               arvalid_q, arvalid_n;
    logic               rready_q, rready_n;
    logic               rsp_valid_n;
    logic [31:0]        rsp_rdata_n;
    logic [1:0]         rsp_resp_n;

    assign cmd_ready   = state == IDLE;
    assign m.M_AWADDR  = addr_q;
    assign m.M_ARADDR  = addr_q;
    assign m.M_WDATA   = wdata_q;
    assign m.M_WSTRB   = wstrb_q;
    assign m.M_AWVALID = awvalid_q;
    assign m.M_WVALID  = wvalid_q;
    assign m.M_BREADY  = bready_q;
    assign m.M_ARVALID = arvalid_q;
    assign m.M_RREADY  = rready_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
        end else begin
            state     <= state_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            wstrb_q   <= wstrb_n;
            awvalid_q <= awvalid_n;
            wvalid_q  <= wvalid_n;
            bready_q  <= bready_n;
            arvalid_q <= arvalid_n;
            rready_q  <= rready_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_resp  <= rsp_resp_n;
        end
    end

    always_comb begin
        state_n     = state;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        wstrb_n     = wstrb_q;
        awvalid_n   = awvalid_q;
        wvalid_n    = wvalid_q;
        bready_n    = bready_q;
        arvalid_n   = arvalid_q;
        rready_n    = rready_q;
        rsp_valid_n = 1'b0;
        rsp_rdata_n = rsp_rdata;
        rsp_resp_n  = rsp_resp;
        case (state)
            IDLE: if (cmd_valid) begin
                addr_n    = cmd_addr;
                wdata_n   = cmd_wdata;
                wstrb_n   = cmd_wstrb;
                awvalid_n = cmd_write;
                wvalid_n  = cmd_write;
                arvalid_n = !cmd_write;
                state_n   = cmd_write ? WRITE : RADDR;
            end
            WRITE: begin
                // Each channel drops after its own handshake; once both are low the
                // address and data phases are complete, in whichever order they came.
                awvalid_n = awvalid_q && !m.M_AWREADY;
                wvalid_n  = wvalid_q && !m.M_WREADY;
                if (!awvalid_n && !wvalid_n) begin
                    state_n  = WRESP;
                    bready_n = 1'b1;
                end
            end
            WRESP: if (m.M_BVALID) begin
                state_n     = IDLE;
                bready_n    = 1'b0;
                rsp_valid_n = 1'b1;
                rsp_rdata_n = '0;
                rsp_resp_n  = m.M_BRESP;
            end
            RADDR: if (m.M_ARREADY) begin
                state_n   = RDATA;
                arvalid_n = 1'b0;
                rready_n  = 1'b1;
            end
            RDATA: if (m.M_RVALID) begin
                state_n     = IDLE;
                rready_n    = 1'b0;
                rsp_valid_n = 1'b1;
                rsp_rdata_n = m.M_RDATA;
                rsp_resp_n  = m.M_RRESP;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi4_lite_master.sv
// tb_axi4_lite_master: directed table of commands against a delay-programmable slave with a small memory
module tb_axi4_lite_master;
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_d, w_d, b_d, ar_d, r_d;
        logic [1:0]  bresp, rresp;
        logic [31:0] e_rdata;
        logic [1:0]  e_resp;
        int          e_lat, e_aw, e_w, e_b, e_ar, e_r;
    } vec_t;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    int tests = 0;
    int fails = 0;

    int aw_d, w_d, b_d, ar_d, r_d;
    logic [1:0] bresp_cfg, rresp_cfg;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic s_aw, s_w, pend_b, pend_r;
    logic [31:0] mem [0:15];

    axi4_lite_if #(.ADDRESS(32)) bus();

    axi4_lite_master #(.ADDRESS(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m(bus)
    );

    always #5 ACLK = ~ACLK;

    wire aw_hs = bus.M_AWVALID && bus.M_AWREADY;
    wire w_hs  = bus.M_WVALID && bus.M_WREADY;
    wire b_hs  = bus.M_BVALID && bus.M_BREADY;
    wire ar_hs = bus.M_ARVALID && bus.M_ARREADY;
    wire r_hs  = bus.M_RVALID && bus.M_RREADY;

    assign bus.M_AWREADY = aw_cnt >= aw_d;
    assign bus.M_WREADY  = w_cnt >= w_d;
    assign bus.M_ARREADY = ar_cnt >= ar_d;
    assign bus.M_BVALID  = pend_b && b_cnt >= b_d;
    assign bus.M_RVALID  = pend_r && r_cnt >= r_d;
    assign bus.M_BRESP   = bresp_cfg;
    assign bus.M_RRESP   = rresp_cfg;
    assign bus.M_RDATA   = mem[bus.M_ARADDR[5:2]];

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            s_aw <= 1'b0; s_w <= 1'b0; pend_b <= 1'b0; pend_r <= 1'b0;
        end else begin
            aw_cnt <= aw_hs ? 0 : bus.M_AWVALID ? aw_cnt + 1 : aw_cnt;
            w_cnt  <= w_hs ? 0 : bus.M_WVALID ? w_cnt + 1 : w_cnt;
            ar_cnt <= ar_hs ? 0 : bus.M_ARVALID ? ar_cnt + 1 : ar_cnt;
            if (aw_hs) s_aw <= 1'b1;
            if (w_hs) s_w <= 1'b1;
            if ((aw_hs || w_hs) && (s_aw || aw_hs) && (s_w || w_hs)) begin
                s_aw <= 1'b0;
                s_w <= 1'b0;
                pend_b <= 1'b1;
                b_cnt <= 0;
                for (int i = 0; i < 4; i++)
                    if (bus.M_WSTRB[i]) mem[bus.M_AWADDR[5:2]][8*i +: 8] <= bus.M_WDATA[8*i +: 8];
            end else if (b_hs) pend_b <= 1'b0;
            else if (pend_b && !bus.M_BVALID) b_cnt <= b_cnt + 1;
            if (ar_hs) begin
                pend_r <= 1'b1;
                r_cnt <= 0;
            end else if (r_hs) pend_r <= 1'b0;
            else if (pend_r && !bus.M_RVALID) r_cnt <= r_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one command starting at a negedge (so it may overlap the previous
    // rsp_valid cycle) and observes the bus at each following negedge until rsp_valid.
    task automatic run(input int idx, input vec_t v);
        int lat, aw_hi, w_hi, b_hi, ar_hi, r_hi;
        logic [31:0] rd, addr_seen, wd_seen;
        logic [3:0] ws_seen;
        logic [1:0] rs;
        lat = -1; aw_hi = 0; w_hi = 0; b_hi = 0; ar_hi = 0; r_hi = 0;
        rd = 'x; rs = 'x; addr_seen = 'x; wd_seen = 'x; ws_seen = 'x;
        aw_d = v.aw_d; w_d = v.w_d; b_d = v.b_d; ar_d = v.ar_d; r_d = v.r_d;
        bresp_cfg = v.bresp; rresp_cfg = v.rresp;
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
        chk($sformatf("v%0d_cmd_ready", idx), 64'(cmd_ready), 64'd1);
        @(posedge ACLK);
        #1 cmd_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge ACLK);
            if (k == 1) begin
                addr_seen = v.wr ? bus.M_AWADDR : bus.M_ARADDR;
                wd_seen = bus.M_WDATA;
                ws_seen = bus.M_WSTRB;
            end
            aw_hi += int'(bus.M_AWVALID);
            w_hi  += int'(bus.M_WVALID);
            b_hi  += int'(bus.M_BREADY);
            ar_hi += int'(bus.M_ARVALID);
            r_hi  += int'(bus.M_RREADY);
            if (rsp_valid) begin
                lat = k;
                rd = rsp_rdata;
                rs = rsp_resp;
                break;
            end
        end
        chk($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.e_lat));
        chk($sformatf("v%0d_rsp_rdata", idx), 64'(rd), 64'(v.e_rdata));
        chk($sformatf("v%0d_rsp_resp", idx), 64'(rs), 64'(v.e_resp));
        chk($sformatf("v%0d_addr_out", idx), 64'(addr_seen), 64'(v.addr));
        chk($sformatf("v%0d_awvalid_cycles", idx), 64'(aw_hi), 64'(v.e_aw));
        chk($sformatf("v%0d_wvalid_cycles", idx), 64'(w_hi), 64'(v.e_w));
        chk($sformatf("v%0d_bready_cycles", idx), 64'(b_hi), 64'(v.e_b));
        chk($sformatf("v%0d_arvalid_cycles", idx), 64'(ar_hi), 64'(v.e_ar));
        chk($sformatf("v%0d_rready_cycles", idx), 64'(r_hi), 64'(v.e_r));
        if (v.wr) chk($sformatf("v%0d_wdata_wstrb", idx), {28'd0, ws_seen, wd_seen}, {28'd0, v.wstrb, v.wdata});
    endtask

    vec_t vecs[9];
    vec_t rv;
    int seen;

    initial begin
        //           wr    addr        wdata         strb   aw w b ar r  bresp rresp  e_rdata       e_resp lat aw w b ar r
        vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'd0, 2'd0, 32'h0,        2'd0, 3, 1, 1, 1, 0, 0};
        vecs[1] = '{1'b0, 32'h10, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 32'hDEADBEEF, 2'd0, 3, 0, 0, 0, 1, 1};
        vecs[2] = '{1'b1, 32'h20, 32'h11223344, 4'hF, 3, 0, 0, 0, 0, 2'd0, 2'd0, 32'h0,        2'd0, 6, 4, 1, 1, 0, 0};
        vecs[3] = '{1'b1, 32'h24, 32'hAABBCCDD, 4'h5, 0, 0, 0, 0, 0, 2'd2, 2'd0, 32'h0,        2'd2, 3, 1, 1, 1, 0, 0};
        vecs[4] = '{1'b0, 32'h24, 32'h0,        4'h0, 0, 0, 0, 0, 4, 2'd0, 2'd3, 32'h00BB00DD, 2'd3, 7, 0, 0, 0, 1, 5};
        vecs[5] = '{1'b1, 32'h30, 32'h55667788, 4'hF, 0, 2, 0, 0, 0, 2'd0, 2'd0, 32'h0,        2'd0, 5, 1, 3, 1, 0, 0};
        vecs[6] = '{1'b0, 32'h20, 32'h0,        4'h0, 0, 0, 0, 2, 0, 2'd0, 2'd0, 32'h11223344, 2'd0, 5, 0, 0, 0, 3, 1};
        vecs[7] = '{1'b1, 32'h30, 32'h0,        4'hC, 1, 1, 2, 0, 0, 2'd0, 2'd0, 32'h0,        2'd0, 6, 2, 2, 3, 0, 0};
        vecs[8] = '{1'b0, 32'h30, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 32'h00007788, 2'd0, 3, 0, 0, 0, 1, 1};
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        aw_d = 0; w_d = 0; b_d = 0; ar_d = 0; r_d = 0; bresp_cfg = 2'd0; rresp_cfg = 2'd0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        ARESETN = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("reset_outputs", {58'd0, bus.M_AWVALID, bus.M_WVALID, bus.M_BREADY, bus.M_ARVALID, bus.M_RREADY, rsp_valid}, 64'd0);
        chk("reset_rsp_data", {30'd0, rsp_resp, rsp_rdata}, 64'd0);
        chk("reset_addr", 64'(bus.M_AWADDR), 64'd0);
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

        // Each vector starts on the negedge where the previous rsp_valid is high,
        // so every transition between vectors is a back-to-back accept.
        for (int i = 0; i < 9; i++) run(i, vecs[i]);

        // Reset while waiting in RDATA: the read must be dropped silently.
        @(negedge ACLK);
        r_d = 20; ar_d = 0; rresp_cfg = 2'd0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10;
        @(posedge ACLK);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("rst_mid_rready_before", {62'd0, bus.M_RREADY, cmd_ready}, 64'd2);
        ARESETN = 1'b0;
        #1;
        chk("rst_mid_outputs", {58'd0, bus.M_AWVALID, bus.M_WVALID, bus.M_BREADY, bus.M_ARVALID, bus.M_RREADY, rsp_valid}, 64'd0);
        chk("rst_mid_rsp_data", {30'd0, rsp_resp, rsp_rdata}, 64'd0);
        chk("rst_mid_araddr", 64'(bus.M_ARADDR), 64'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge ACLK);
            seen += int'(rsp_valid);
        end
        chk("rst_mid_no_rsp", 64'(seen), 64'd0);
        rv = '{1'b0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 32'hDEADBEEF, 2'd0, 3, 0, 0, 0, 1, 1};
        run(9, rv);
        @(negedge ACLK);
        chk("rsp_valid_single_pulse", 64'(rsp_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axi4_lite_master.md
AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
REQ-001 SHALL provide parameter: ADDRESS, 32, AXI address width; data width fixed at 32, strobe width fixed at 4.
REQ-002 SHALL provide port: ACLK  in  1  clock; all logic on rising edge.
REQ-003 SHALL provide port: ARESETN  in  1  reset; asynchronous, active-low.
REQ-004 SHALL provide port: cmd_valid  in  1  user command request.
REQ-005 SHALL provide port: cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
REQ-006 SHALL provide port: cmd_write  in  1  1=write, 0=read.
REQ-007 SHALL provide port: cmd_addr  in  ADDRESS  target byte address.
REQ-008 SHALL provide port: cmd_wdata  in  32  write data.
REQ-009 SHALL provide port: cmd_wstrb  in  4  write byte strobes.
REQ-010 SHALL provide port: rsp_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL provide port: rsp_rdata  out  32  read data; 0 for writes.
REQ-012 SHALL provide port: rsp_resp  out  2  captured BRESP/RRESP.
REQ-013 SHALL provide port: M_AWADDR  out  ADDRESS  write address.
REQ-014 SHALL provide port: M_AWVALID  out  1  write address valid.
REQ-015 SHALL provide port: M_AWREADY  in  1  write address ready.
REQ-016 SHALL provide port: M_WDATA  out  32  write data.
REQ-017 SHALL provide port: M_WSTRB  out  4  write strobes.
REQ-018 SHALL provide port: M_WVALID  out  1  write data valid.
REQ-019 SHALL provide port: M_WREADY  in  1  write data ready.
REQ-020 SHALL provide port: M_BRESP  in  2  write response.
REQ-021 SHALL provide port: M_BVALID  in  1  write response valid.
REQ-022 SHALL provide port: M_BREADY  out  1  write response ready.
REQ-023 SHALL provide port: M_ARADDR  out  ADDRESS  read address.
REQ-024 SHALL provide port: M_ARVALID  out  1  read address valid.
REQ-025 SHALL provide port: M_ARREADY  in  1  read address ready.
REQ-026 SHALL provide port: M_RDATA  in  32  read data.
REQ-027 SHALL provide port: M_RRESP  in  2  read response.
REQ-028 SHALL provide port: M_RVALID  in  1  read data valid.
REQ-029 SHALL provide port: M_RREADY  out  1  read data ready.

Function
REQ-030 SHALL implement FSM IDLE, WRITE, WRESP, RADDR, RDATA; all AXI outputs and rsp_* registered; cmd_ready=1 only in IDLE.
REQ-031 SHALL on command accept latch addr/wdata/wstrb, go WRITE (cmd_write=1) or RADDR (cmd_write=0); AXI address/data outputs held stable from latch until the next accept.
REQ-032 SHALL in WRITE assert M_AWVALID and M_WVALID together from the cycle after accept, drop each independently the cycle after its own handshake, never re-assert within one transaction, and go WRESP once both handshakes have occurred (same-cycle or either order).
REQ-033 SHALL in WRESP hold M_BREADY=1; on M_BVALID capture M_BRESP into rsp_resp, set rsp_rdata=0, pulse rsp_valid next cycle, return IDLE.
REQ-034 SHALL in RADDR hold M_ARVALID=1 until M_ARREADY, then go RDATA with M_RREADY=1 until M_RVALID; capture M_RDATA/M_RRESP, pulse rsp_valid next cycle, return IDLE.
REQ-035 SHALL with always-ready slave: write rsp_valid at cycle 3 after accept (AW/W at 1, B at 2); read rsp_valid at cycle 3 (AR at 1, R at 2).
REQ-036 SHALL accept a new command in the same cycle rsp_valid is high (back-to-back allowed); only one outstanding transaction.
REQ-037 SHALL ignore M_BVALID/M_RVALID outside WRESP/RDATA; valids never depend combinationally on readys.
REQ-038 SHALL pass non-OKAY responses (SLVERR=2, DECERR=3) through rsp_resp without retry.

Reset
REQ-039 SHALL on ARESETN low force IDLE, all M_*VALID, M_BREADY, M_RREADY, rsp_valid=0, rsp_rdata=0, rsp_resp=0, address/data registers=0; cmd_ready=1 after release.
REQ-040 SHALL abandon an in-flight transaction on reset with no rsp_valid issued.

Verification
REQ-041 SHALL cover: write 0x10/0xDEADBEEF/wstrb 0xF to always-ready slave -> AW/W valid at cycle 1, rsp_valid at cycle 3, rsp_resp=0.
REQ-042 SHALL cover: read 0x10 after above -> M_ARADDR=0x10, rsp_rdata=0xDEADBEEF, rsp_resp=0.
REQ-043 SHALL cover: AWREADY delayed 3 cycles, WREADY immediate -> WVALID high 1 cycle, AWVALID held 4 cycles, single BREADY phase.
REQ-044 SHALL cover: slave returns BRESP=2, then RVALID delayed 5 cycles with RRESP=3 -> rsp_resp=2, then RREADY held 5 cycles, rsp_resp=3.
REQ-045 SHALL cover: ARESETN low while in RDATA -> all valids/readys 0, no rsp_valid, next read completes normally.
